log_mag_pipe: RTL and testbench

- Streaming fixed-point log2 magnitude estimator for complex samples. It is the parametrised successor of the single-LUT log-magnitude stage.
- Computes log2(|z|^2) as integer part plus FRAC_BITS fraction, or optionally log2(|z|).
- Uses a small elaboration-generated LUT with linear interpolation in place of a 2^DATA_WIDTH table.
- Has a full valid/ready handshake with bubble-collapsing stalls. Sits between the FFT output and the spectrum/display path; flags_t metadata passes through aligned with the data.

---
 rtl/log_mag_pipe.sv | 199 +++++++++++++++++++
 tb/tb_log_mag_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/log_mag_pipe.sv
// Streaming log2 magnitude estimator for complex samples.
// Output is log2(|z|^2) in INT_BITS.FRAC_BITS, or log2|z| when half_mode is set.
// Four registered stages: square, sum, normalise + LUT fetch, interpolate.
// Each stage has its own valid bit, so empty stages keep accepting while the
// output is stalled.
package log_mag_pkg;
  typedef struct packed {
    logic       sof;
    logic       eof;
    logic [5:0] tag;
  } flags_t;
endpackage

module log_mag_pipe
  import log_mag_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8,
  parameter int LUT_BITS   = 6,
  localparam int INT_BITS  = $clog2(2*DATA_WIDTH+1),
  localparam int OUT_WIDTH = INT_BITS + FRAC_BITS
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  flags_t                       flags_in,
  input  logic signed [DATA_WIDTH-1:0] z_re,
  input  logic signed [DATA_WIDTH-1:0] z_im,
  input  logic                         half_mode,
  output logic                         out_valid,
  input  logic                         out_ready,
  output flags_t                       flags_out,
  output logic        [OUT_WIDTH-1:0]  log2_mag,
  output logic                         is_zero
);

  localparam int PW       = 2*DATA_WIDTH;      // width of a square
  localparam int MW       = PW + 1;            // width of the sum of squares
  localparam int NL       = 2**LUT_BITS + 1;   // LUT entries incl. endpoint
  localparam int ACC_BITS = 20;                // log2 bits computed before rounding

  typedef logic [NL-1:0][FRAC_BITS:0] lut_t;

  // Fixed-point log2 by repeated squaring of x in [1,2), kept in Q30.
  // Each squaring yields one fractional bit; the result is rounded to FRAC_BITS.
  function automatic lut_t build_lut();
    lut_t        t;
    logic [63:0] x;
    logic [31:0] acc;
    for (int k = 0; k < NL; k++) begin
      if (k == 2**LUT_BITS) begin
        t[k] = (FRAC_BITS+1)'(2**FRAC_BITS);
      end else begin
        x   = 64'(2**LUT_BITS + k) << (30 - LUT_BITS);
        acc = '0;
        for (int i = 0; i < ACC_BITS; i++) begin
          x   = (x * x) >> 30;
          acc = acc << 1;
          if (x >= (64'd2 << 30)) begin
            x   = x >> 1;
            acc = acc | 32'd1;
          end
        end
        t[k] = (FRAC_BITS+1)'((acc + (32'd1 << (ACC_BITS-FRAC_BITS-1))) >> (ACC_BITS-FRAC_BITS));
      end
    end
    return t;
  endfunction

  localparam lut_t LUT = build_lut();

  logic [4:1] vld_pipe;
  logic [4:1] ld;

  // Stage k loads when empty or when its successor is taking its contents.
  always_comb begin
    ld[4] = !vld_pipe[4] || out_ready;
    for (int k = 3; k >= 1; k--) ld[k] = !vld_pipe[k] || ld[k+1];
  end

  assign in_ready  = ld[1];
  assign out_valid = vld_pipe[4];

  // Valid bits advance independently so bubbles collapse.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_pipe <= '0;
    end else begin
      if (ld[1]) vld_pipe[1] <= in_valid;
      for (int k = 2; k <= 4; k++)
        if (ld[k]) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  // ---------------- S1: squares ----------------
  logic signed [PW-1:0] re_sx, im_sx;
  logic        [PW-1:0] s1_re2, s1_im2;
  flags_t               s1_flags;
  logic                 s1_half;

  assign re_sx = PW'(z_re);
  assign im_sx = PW'(z_im);

  // Register squares; squares are non-negative so they fit unsigned PW bits.
  always_ff @(posedge clk) begin
    if (ld[1] && in_valid) begin
      s1_re2   <= re_sx * re_sx;
      s1_im2   <= im_sx * im_sx;
      s1_flags <= flags_in;
      s1_half  <= half_mode;
    end
  end

  // ---------------- S2: magnitude squared ----------------
  logic [MW-1:0] s2_m;
  flags_t        s2_flags;
  logic          s2_half;

  // One extra bit makes the sum overflow-free.
  always_ff @(posedge clk) begin
    if (ld[2] && vld_pipe[1]) begin
      s2_m     <= {1'b0, s1_re2} + {1'b0, s1_im2};
      s2_flags <= s1_flags;
      s2_half  <= s1_half;
    end
  end

  // ---------------- S3: normalise, LUT fetch ----------------
  logic [INT_BITS-1:0] p, shamt;
  logic [MW-1:0]       sh;
  logic [PW-1:0]       f;
  logic [LUT_BITS-1:0] idx;
  logic [LUT_BITS:0]   idx1;
  logic [FRAC_BITS-1:0] r;

  // Priority search for the msb; lowest-to-highest so the top set bit wins.
  always_comb begin
    p = '0;
    for (int i = 0; i < MW; i++)
      if (s2_m[i]) p = INT_BITS'(i);
  end

  // Shift the leading one to the top bit; what lies below it is the mantissa.
  assign shamt = INT_BITS'(MW-1) - p;
  assign sh    = s2_m << shamt;
  assign f     = sh[MW-2:0];
  assign idx   = f[PW-1 -: LUT_BITS];
  assign r     = f[PW-1-LUT_BITS -: FRAC_BITS];
  assign idx1  = {1'b0, idx} + 1'b1;

  logic [FRAC_BITS:0]   s3_l0, s3_l1;
  logic [FRAC_BITS-1:0] s3_r;
  logic [INT_BITS-1:0]  s3_p;
  logic                 s3_zero;
  flags_t               s3_flags;
  logic                 s3_half;

  // Fetch both interpolation endpoints so S4 is just a multiply-add.
  always_ff @(posedge clk) begin
    if (ld[3] && vld_pipe[2]) begin
      s3_l0    <= LUT[idx];
      s3_l1    <= LUT[idx1];
      s3_r     <= r;
      s3_p     <= p;
      s3_zero  <= (s2_m == '0);
      s3_flags <= s2_flags;
      s3_half  <= s2_half;
    end
  end

  // ---------------- S4: interpolate, assemble ----------------
  logic [FRAC_BITS:0]     diff, frac;
  logic [2*FRAC_BITS:0]   prod;
  logic [OUT_WIDTH-1:0]   res;

  assign diff = s3_l1 - s3_l0;
  assign prod = (2*FRAC_BITS+1)'(diff) * (2*FRAC_BITS+1)'(s3_r);
  assign frac = s3_l0 + prod[2*FRAC_BITS:FRAC_BITS];
  // Full-width add lets frac == 2^FRAC_BITS carry into the integer part.
  assign res  = {s3_p, {FRAC_BITS{1'b0}}} + OUT_WIDTH'(frac);

  // Output register; holds while downstream stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      log2_mag  <= '0;
      is_zero   <= 1'b0;
      flags_out <= '0;
    end else if (ld[4] && vld_pipe[3]) begin
      log2_mag  <= s3_zero ? '0 : (s3_half ? (res >> 1) : res);
      is_zero   <= s3_zero;
      flags_out <= s3_flags;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{sh[MW-1], f[PW-LUT_BITS-FRAC_BITS-1:0], prod[FRAC_BITS-1:0]};

endmodule

// File: tb/tb_log_mag_pipe.sv
// Bench for log_mag_pipe: directed values, randomised handshake, reset flush.
module tb_log_mag_pipe;
  import log_mag_pkg::*;

  logic               clk, reset;
  logic               in_valid, in_ready, half_mode, out_valid, out_ready, is_zero;
  flags_t             flags_in, flags_out;
  logic signed [15:0] z_re, z_im;
  logic        [13:0] log2_mag;

  log_mag_pipe #(.DATA_WIDTH(16), .FRAC_BITS(8), .LUT_BITS(6)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .flags_in(flags_in), .z_re(z_re), .z_im(z_im), .half_mode(half_mode),
    .out_valid(out_valid), .out_ready(out_ready), .flags_out(flags_out),
    .log2_mag(log2_mag), .is_zero(is_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    flags_t      fl;
    logic [13:0] mag;
    bit          z;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          nchk = 0, nfail = 0, npop = 0;
  bit          lat_chk = 0;
  bit          prev_stall = 0;
  logic [13:0] prev_mag;
  flags_t      prev_fl;
  bit          prev_z;
  int          lut[0:64];

  task automatic chk(input string tag, input longint got, input longint exp);
    nchk++;
    if (got !== exp) begin
      nfail++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: real-valued LUT, then the interpolation as described.
  function automatic void model(input int re, input int im, input bit hm,
                                output logic [13:0] mag, output bit z);
    longint m, f, idx, r, frac, res;
    int p;
    m = longint'(re)*re + longint'(im)*im;
    z = (m == 0);
    mag = '0;
    if (m != 0) begin
      p = 0;
      for (int i = 0; i < 33; i++) if ((m >> i) & 1) p = i;
      f    = (m - (64'sd1 << p)) << (32 - p);
      idx  = (f >> 26) & 63;
      r    = (f >> 18) & 255;
      frac = lut[idx] + (((lut[idx+1] - lut[idx]) * r) >> 8);
      res  = p*256 + frac;
      if (hm) res = res >> 1;
      mag = 14'(res);
    end
  endfunction

  // One cycle: drive at negedge, check and update scoreboard just after.
  task automatic step(input bit iv, input int re, input int im, input bit hm,
                      input flags_t fl, input bit ordy,
                      input logic [13:0] emag, input bit ez, output bit acc);
    exp_t e;
    @(negedge clk);
    in_valid = iv; z_re = 16'(re); z_im = 16'(im); half_mode = hm;
    flags_in = fl; out_ready = ordy;
    #1;
    if (prev_stall) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_mag", log2_mag, prev_mag);
      chk("hold_flags", flags_out, prev_fl);
      chk("hold_zero", is_zero, prev_z);
    end
    chk("in_ready", in_ready, !(sb.size() == 4 && !ordy));
    if (out_valid) chk("out_has_item", sb.size() > 0, 1);
    if (out_valid && out_ready && sb.size() > 0) begin
      e = sb.pop_front();
      npop++;
      chk("flags", flags_out, e.fl);
      chk("mag", log2_mag, e.mag);
      chk("zero", is_zero, e.z);
      if (lat_chk) chk("latency", cyc - e.cyc, 4);
    end
    acc = iv && in_ready;
    if (acc) begin
      e.fl = fl; e.mag = emag; e.z = ez; e.cyc = cyc;
      sb.push_back(e);
    end
    prev_stall = out_valid && !out_ready;
    prev_mag = log2_mag; prev_fl = flags_out; prev_z = is_zero;
  endtask

  task automatic send(input int re, input int im, input bit hm, input int tag,
                      input logic [13:0] emag, input bit ez);
    bit a;
    flags_t fl;
    fl = '{sof: 1'b0, eof: 1'b0, tag: 6'(tag)};
    step(1, re, im, hm, fl, 1, emag, ez, a);
    chk("send_acc", a, 1);
  endtask

  task automatic idle(input int n);
    bit a;
    repeat (n) step(0, 0, 0, 0, '0, 1, '0, 0, a);
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(0, 0, 0, 0, '0, 1, '0, 0, a);
    chk("drain", sb.size(), 0);
  endtask

  task automatic reset_check();
    chk("rst_valid", out_valid, 0);
    chk("rst_mag", log2_mag, 0);
    chk("rst_zero", is_zero, 0);
    chk("rst_flags", flags_out, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit a;
    int sent, n0, re, im;
    bit hm;
    logic [13:0] em;
    bit ez;
    flags_t fl;

    for (int k = 0; k <= 64; k++)
      lut[k] = $rtoi($ln(1.0 + k/64.0) / $ln(2.0) * 256.0 + 0.5);

    reset = 1; in_valid = 0; out_ready = 0; z_re = 0; z_im = 0; half_mode = 0; flags_in = '0;
    repeat (3) @(negedge clk);
    #1;
    reset_check();
    reset = 0;

    // Directed values, back-to-back with out_ready high.
    lat_chk = 1;
    send(1, 0, 0, 1, 14'h0000, 0);
    send(0, 0, 0, 2, 14'h0000, 1);
    send(3, 4, 0, 3, 14'd1189, 0);
    send(3, 4, 1, 4, 14'd594, 0);
    send(11, 4, 0, 5, 14'd1817, 0);
    send(-32768, -32768, 0, 6, 14'd7936, 0);
    send(-32768, -32768, 1, 7, 14'd3968, 0);
    send(256, 0, 0, 8, 14'd4096, 0);
    send(0, -1, 0, 9, 14'd0, 0);
    send(0, 0, 1, 10, 14'd0, 1);
    drain();

    // Full-throughput burst of model-checked samples: outputs on 8 consecutive cycles.
    for (int i = 0; i < 12; i++) begin
      if (i == 4) n0 = npop;
      if (i < 8) begin
        re = $urandom_range(0, 65535) - 32768; im = $urandom_range(0, 65535) - 32768;
        hm = 1'(i & 1);
        model(re, im, hm, em, ez);
        fl = '{sof: 1'b0, eof: 1'b0, tag: 6'(20 + i)};
        step(1, re, im, hm, fl, 1, em, ez, a);
      end else begin
        step(0, 0, 0, 0, '0, 1, '0, 0, a);
      end
    end
    chk("burst_cnt", npop - n0, 8);

    // Hold out_ready low while feeding: pipe fills, in_ready must drop, outputs hold.
    lat_chk = 0;
    for (int i = 0; i < 8; i++) begin
      re = i * 100 + 1; im = -i;
      model(re, im, 0, em, ez);
      fl = '{sof: 1'b0, eof: 1'b0, tag: 6'(30 + i)};
      step(1, re, im, 0, fl, 0, em, ez, a);
    end
    drain();

    // Random handshake: 20 flagged samples, random bubbles and backpressure.
    sent = 0;
    for (int i = 0; i < 400 && sent < 20; i++) begin
      if (sent < 20 && ($urandom % 4) != 0) begin
        re = ($urandom % 2) ? $urandom_range(0, 65535) - 32768 : $urandom_range(0, 64) - 32;
        im = ($urandom % 2) ? $urandom_range(0, 65535) - 32768 : $urandom_range(0, 64) - 32;
        hm = 1'($urandom % 2);
        model(re, im, hm, em, ez);
        fl = '{sof: (sent == 0), eof: (sent == 19), tag: 6'(sent)};
        step(1, re, im, hm, fl, 1'($urandom % 2), em, ez, a);
        if (a) sent++;
      end else begin
        step(0, 0, 0, 0, '0, 1'($urandom % 2), '0, 0, a);
      end
    end
    chk("rand_sent", sent, 20);
    drain();

    // Reset with three samples in flight; none may emerge afterwards.
    lat_chk = 1;
    send(5, 5, 0, 50, 14'd0, 0);
    send(7, 1, 0, 51, 14'd0, 0);
    send(9, 9, 0, 52, 14'd0, 0);
    @(negedge clk);
    reset = 1; in_valid = 0; out_ready = 1;
    @(negedge clk);
    #1;
    reset_check();
    sb.delete();
    prev_stall = 0;
    reset = 0;
    idle(8);
    send(3, 4, 0, 53, 14'd1189, 0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
